// File: rtl/batch_sample_sequencer_if.sv
// Sample-stream / RAM-side bundle for batch_sample_sequencer.
// master: the sample source that also consumes the RAM strobes and addresses.
// slave:  the sequencer itself.
// N, OSR and DEPTH must match the sequencer instance so the widths line up.
interface batch_sample_sequencer_if #(
    parameter int N     = 4,
    parameter int OSR   = 1,
    parameter int DEPTH = 220,
    localparam int DSD  = (DEPTH + OSR - 1) / OSR,
    localparam int AW   = $clog2(4 * DSD)
);
    logic [N-1:0]     in;
    logic             inValid;
    logic             sampleWrite;
    logic [N*OSR-1:0] sampleDataIn;
    logic [AW-1:0]    sampleAddrIn;
    logic [AW-1:0]    sampleAddrOut1;
    logic [AW-1:0]    sampleAddrOut2;
    logic [AW-1:0]    sampleAddrOut3;
    logic             outValid;
    logic             batchStart;

    modport master (
        output in, inValid,
        input  sampleWrite, sampleDataIn, sampleAddrIn,
        input  sampleAddrOut1, sampleAddrOut2, sampleAddrOut3,
        input  outValid, batchStart
    );

    modport slave (
        input  in, inValid,
        output sampleWrite, sampleDataIn, sampleAddrIn,
        output sampleAddrOut1, sampleAddrOut2, sampleAddrOut3,
        output outValid, batchStart
    );
endinterface

// File: rtl/batch_sample_sequencer.sv
// batch_sample_sequencer: packs OSR input samples per RAM word, writes the
// words into a 4-segment circular sample RAM and produces the three read
// addresses of the batch recursion for every word written.
// Optional build macro: BATCH_SEQ_REG_OUT_EN adds one register stage on the
// read addresses, outValid and batchStart (they then lag sampleWrite by 1).
//
// Handshake: there is no backpressure. A sample on bus.in is consumed on
// every rising edge where bus.inValid is 1; bus.sampleWrite is a one-cycle
// strobe that the RAM must accept unconditionally. Idle cycles freeze state.
module batch_sample_sequencer #(
    parameter int N     = 4,
    parameter int OSR   = 1,
    parameter int DEPTH = 220,
    localparam int DSD  = (DEPTH + OSR - 1) / OSR,
    localparam int AW   = $clog2(4 * DSD)
) (
    input  logic                     clk,
    input  logic                     rst,
    batch_sample_sequencer_if.slave  bus
);
    localparam int PCW = (OSR > 1) ? $clog2(OSR) : 1;
    localparam int OFW = (DSD > 1) ? $clog2(DSD) : 1;
    localparam int WW  = N * OSR;

    typedef enum logic {FILL = 1'b0, RUN = 1'b1} state_t;

    state_t         state, nextState;
    logic [1:0]     fillCnt;
    logic [PCW-1:0] pc;
    logic [WW-1:0]  packReg, packNext;
    logic [AW-1:0]  wp;
    logic [1:0]     seg;
    logic [OFW-1:0] off;
    logic           groupDone, segDone;
    logic           outValidNext, batchStartNext;
    logic [AW-1:0]  rdAddr1, rdAddr2, rdAddr3;

    logic           writeQ;
    logic [WW-1:0]  dataQ;
    logic [AW-1:0]  addrInQ, addr1Q, addr2Q, addr3Q;
    logic           outValidQ, batchStartQ;

    // The sample on bus.in closes a group; segDone marks the last word of a segment.
    assign groupDone = bus.inValid && (pc == PCW'(OSR - 1));
    assign segDone   = (off == OFW'(DSD - 1));

    // Start address of segment s; segment indices wrap mod 4 via the 2-bit argument.
    function automatic logic [AW-1:0] segBase(input logic [1:0] s);
        return AW'(int'(s) * DSD);
    endfunction

    // Current group with the incoming sample dropped into its slot (first sample in LSBs).
    always_comb begin
        packNext = packReg;
        packNext[int'(pc) * N +: N] = bus.in;
    end

    // Read addresses for the word being written: backward over w-1 and w-2, forward over w-3.
    always_comb begin
        rdAddr1 = segBase(seg - 2'd1) + AW'(DSD - 1 - int'(off));
        rdAddr2 = segBase(seg - 2'd2) + AW'(DSD - 1 - int'(off));
        rdAddr3 = segBase(seg - 2'd3) + AW'(off);
    end

    // FSM state register plus the count of segments completed while filling.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= FILL;
            fillCnt <= 2'd0;
        end else begin
            state <= nextState;
            if (state == FILL && groupDone && segDone) begin
                fillCnt <= fillCnt + 2'd1;
            end
        end
    end

    // FSM next state: the write completing the third segment starts RUN.
    always_comb begin
        nextState = state;
        if (state == FILL && groupDone && segDone && fillCnt == 2'd2) begin
            nextState = RUN;
        end
    end

    // FSM outputs: only writes issued from RUN reference fully written data.
    always_comb begin
        outValidNext   = 1'b0;
        batchStartNext = 1'b0;
        if (state == RUN) begin
            outValidNext   = groupDone;
            batchStartNext = groupDone && (off == '0);
        end
    end

    // Pack counter, group buffer and write pointer (split into segment and offset).
    always_ff @(posedge clk) begin
        if (rst) begin
            pc      <= '0;
            packReg <= '0;
            wp      <= '0;
            seg     <= 2'd0;
            off     <= '0;
        end else if (bus.inValid) begin
            if (groupDone) begin
                pc      <= '0;
                packReg <= '0;
                wp      <= (wp == AW'(4 * DSD - 1)) ? '0 : wp + 1'b1;
                if (segDone) begin
                    off <= '0;
                    seg <= seg + 2'd1;
                end else begin
                    off <= off + 1'b1;
                end
            end else begin
                pc      <= pc + 1'b1;
                packReg <= packNext;
            end
        end
    end

    // Write strobe and word/addresses registered together; addresses hold between writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            writeQ      <= 1'b0;
            dataQ       <= '0;
            addrInQ     <= '0;
            addr1Q      <= '0;
            addr2Q      <= '0;
            addr3Q      <= '0;
            outValidQ   <= 1'b0;
            batchStartQ <= 1'b0;
        end else begin
            writeQ      <= groupDone;
            outValidQ   <= outValidNext;
            batchStartQ <= batchStartNext;
            if (groupDone) begin
                dataQ   <= packNext;
                addrInQ <= wp;
                addr1Q  <= rdAddr1;
                addr2Q  <= rdAddr2;
                addr3Q  <= rdAddr3;
            end
        end
    end

    assign bus.sampleWrite  = writeQ;
    assign bus.sampleDataIn = dataQ;
    assign bus.sampleAddrIn = addrInQ;

`ifdef BATCH_SEQ_REG_OUT_EN
    logic [AW-1:0] addr1D, addr2D, addr3D;
    logic          outValidD, batchStartD;

    // Extra stage on the read side for timing closure at the RAM read port.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr1D      <= '0;
            addr2D      <= '0;
            addr3D      <= '0;
            outValidD   <= 1'b0;
            batchStartD <= 1'b0;
        end else begin
            addr1D      <= addr1Q;
            addr2D      <= addr2Q;
            addr3D      <= addr3Q;
            outValidD   <= outValidQ;
            batchStartD <= batchStartQ;
        end
    end

    assign bus.sampleAddrOut1 = addr1D;
    assign bus.sampleAddrOut2 = addr2D;
    assign bus.sampleAddrOut3 = addr3D;
    assign bus.outValid       = outValidD;
    assign bus.batchStart     = batchStartD;
`else
    assign bus.sampleAddrOut1 = addr1Q;
    assign bus.sampleAddrOut2 = addr2Q;
    assign bus.sampleAddrOut3 = addr3Q;
    assign bus.outValid       = outValidQ;
    assign bus.batchStart     = batchStartQ;
`endif

endmodule
